// File: rtl/zicsr_csr_file.sv
// zicsr_csr_file: ustatus/mstatus/mtvec/mhartid CSR file with a three-state
// IDLE/EXEC/RESP handshake FSM for Zicsr RW/RS/RC instructions.
// Ports: clk, reset (async active-low), req_* request channel,
//        rsp_* response channel, int_we/int_wdata internal writes,
//        csr_mstatus/csr_mtvec live CSR values.
// Config: define ZICSR_ILLEGAL_TRAP_EN to report illegality on rsp_illegal.
module zicsr_csr_file #(
    parameter int unsigned     XLEN          = 32,
    parameter logic [XLEN-1:0] MSTATUS_WMASK = 32'h0000_1888,
    parameter logic [XLEN-1:0] MTVEC_WMASK   = 32'hFFFF_FFFC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [11:0]     req_addr,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_src,
    input  logic            req_rd_nz,
    input  logic            req_src_nz,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_illegal,
    input  logic [3:0]      int_we,
    input  logic [XLEN-1:0] int_wdata,
    output logic [XLEN-1:0] csr_mstatus,
    output logic [XLEN-1:0] csr_mtvec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [XLEN-1:0] MSTATUS_RST = XLEN'(32'h0000_1880);
    localparam logic [XLEN-1:0] MTVEC_RST   = XLEN'(32'h8000_0000);

    state_e          state_q, state_d;
    logic [11:0]     addr_q, addr_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] src_q, src_d;
    logic            rd_nz_q, rd_nz_d;
    logic            src_nz_q, src_nz_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_illegal_q, rsp_illegal_d;
    logic [XLEN-1:0] ustatus_q, ustatus_d;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mhartid_q, mhartid_d;

    logic            hit_us, hit_ms, hit_tv, hit_hi;
    logic            mapped, writable, readable;
    logic [XLEN-1:0] old_val, new_val, wr_val, wmask;
    logic            do_wr, do_rd, illegal, illegal_rpt, wr_en;

    // Decode and datapath for the latched request
    always_comb begin
        hit_us   = (addr_q == 12'h000);
        hit_ms   = (addr_q == 12'h300);
        hit_tv   = (addr_q == 12'h305);
        hit_hi   = (addr_q == 12'hF14);
        mapped   = 1'b1;
        writable = 1'b0;
        readable = 1'b0;
        old_val  = '0;
        wmask    = '0;
        unique case (1'b1)
            hit_us: begin
                old_val  = ustatus_q;
                readable = 1'b1;
            end
            hit_ms: begin
                old_val  = mstatus_q;
                wmask    = MSTATUS_WMASK;
                writable = 1'b1;
                readable = 1'b1;
            end
            hit_tv: begin
                old_val  = mtvec_q;
                wmask    = MTVEC_WMASK;
                writable = 1'b1;
            end
            hit_hi: begin
                old_val  = mhartid_q;
                readable = 1'b1;
            end
            default: mapped = 1'b0;
        endcase

        unique case (op_q)
            OP_RS:   new_val = old_val | src_q;
            OP_RC:   new_val = old_val & ~src_q;
            default: new_val = src_q;
        endcase

        // RW with rd=x0 skips the read; RS/RC with rs1=x0 skip the write
        do_wr   = (op_q == OP_RW) || src_nz_q;
        do_rd   = (op_q != OP_RW) || rd_nz_q;
        illegal = !mapped || (op_q == 2'b00)
                  || (do_wr && !writable)
                  || (do_rd && !readable);
        wr_en   = (state_q == EXEC) && !illegal && do_wr;
        wr_val  = (new_val & wmask) | (old_val & ~wmask);
`ifdef ZICSR_ILLEGAL_TRAP_EN
        illegal_rpt = illegal;
`else
        illegal_rpt = 1'b0;
`endif
    end

    // CSR next state; internal writes win over instruction writes
    always_comb begin
        ustatus_d = ustatus_q;
        mstatus_d = mstatus_q;
        mtvec_d   = mtvec_q;
        mhartid_d = mhartid_q;
        if (wr_en && hit_ms) mstatus_d = wr_val;
        if (wr_en && hit_tv) mtvec_d   = wr_val;
        if (int_we[0]) ustatus_d = int_wdata;
        if (int_we[1]) mstatus_d = int_wdata;
        if (int_we[2]) mtvec_d   = int_wdata;
        if (int_we[3]) mhartid_d = int_wdata;
    end

    // Handshake FSM
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        op_d          = op_q;
        src_d         = src_q;
        rd_nz_d       = rd_nz_q;
        src_nz_d      = src_nz_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_illegal_d = rsp_illegal_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = EXEC;
                    addr_d   = req_addr;
                    op_d     = req_op;
                    src_d    = req_src;
                    rd_nz_d  = req_rd_nz;
                    src_nz_d = req_src_nz;
                end
            end
            EXEC: begin
                state_d       = RESP;
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = (do_rd && !illegal) ? old_val : '0;
                rsp_illegal_d = illegal_rpt;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_illegal_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            op_q          <= '0;
            src_q         <= '0;
            rd_nz_q       <= 1'b0;
            src_nz_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
            ustatus_q     <= '0;
            mstatus_q     <= MSTATUS_RST;
            mtvec_q       <= MTVEC_RST;
            mhartid_q     <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            op_q          <= op_d;
            src_q         <= src_d;
            rd_nz_q       <= rd_nz_d;
            src_nz_q      <= src_nz_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_illegal_q <= rsp_illegal_d;
            ustatus_q     <= ustatus_d;
            mstatus_q     <= mstatus_d;
            mtvec_q       <= mtvec_d;
            mhartid_q     <= mhartid_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_illegal = rsp_illegal_q;
    assign csr_mstatus = mstatus_q;
    assign csr_mtvec   = mtvec_q;

endmodule

// File: tb/tb_zicsr_csr_file.sv
// tb_zicsr_csr_file: directed self-checking bench for zicsr_csr_file.
// Expectations follow ZICSR_ILLEGAL_TRAP_EN when it is defined.
module tb_zicsr_csr_file;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_src;
    logic        req_rd_nz;
    logic        req_src_nz;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_illegal;
    logic [3:0]  int_we;
    logic [31:0] int_wdata;
    logic [31:0] csr_mstatus;
    logic [31:0] csr_mtvec;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef ZICSR_ILLEGAL_TRAP_EN
    localparam logic [31:0] ILL = 32'd1;
`else
    localparam logic [31:0] ILL = 32'd0;
`endif

    zicsr_csr_file dut (
        .clk         (clk),
        .reset       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_op      (req_op),
        .req_src     (req_src),
        .req_rd_nz   (req_rd_nz),
        .req_src_nz  (req_src_nz),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_illegal (rsp_illegal),
        .int_we      (int_we),
        .int_wdata   (int_wdata),
        .csr_mstatus (csr_mstatus),
        .csr_mtvec   (csr_mtvec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE; returns at the negedge after the
    // response edge with rsp_ready still low.
    task automatic issue(input logic [11:0] a, input logic [1:0] op,
                         input logic [31:0] src, input logic rdnz,
                         input logic srcnz, input logic [3:0] iwe,
                         input logic [31:0] iwd);
        req_valid  = 1'b1;
        req_addr   = a;
        req_op     = op;
        req_src    = src;
        req_rd_nz  = rdnz;
        req_src_nz = srcnz;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        int_we    = iwe;
        int_wdata = iwd;
        @(negedge clk);
        chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
        chk("exec_not_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        int_we    = 4'b0;
        int_wdata = 32'h0;
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_done", 32'(rsp_valid), 32'd0);
        chk("ready_again", 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 12'h0;
        req_op     = 2'b00;
        req_src    = 32'h0;
        req_rd_nz  = 1'b0;
        req_src_nz = 1'b0;
        rsp_ready  = 1'b0;
        int_we     = 4'b0;
        int_wdata  = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_illegal", 32'(rsp_illegal), 32'd0);
        chk("rst_mstatus", csr_mstatus, 32'h0000_1880);
        chk("rst_mtvec", csr_mtvec, 32'h8000_0000);
        rst_n = 1'b1;
        @(negedge clk);

        // RS mstatus with rs1=x0: read only
        issue(12'h300, 2'b10, 32'h0, 1'b1, 1'b0, 4'b0, 32'h0);
        chk("rs_rdata", rsp_rdata, 32'h0000_1880);
        chk("rs_illegal", 32'(rsp_illegal), 32'd0);
        chk("rs_mstatus", csr_mstatus, 32'h0000_1880);
        ack();

        // RW mstatus all ones: masked write
        issue(12'h300, 2'b01, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'b0, 32'h0);
        chk("rw_rdata", rsp_rdata, 32'h0000_1880);
        chk("rw_mstatus", csr_mstatus, 32'h0000_1888);
        ack();

        // RC mstatus bit 3
        issue(12'h300, 2'b11, 32'h8, 1'b1, 1'b1, 4'b0, 32'h0);
        chk("rc_rdata", rsp_rdata, 32'h0000_1888);
        chk("rc_mstatus", csr_mstatus, 32'h0000_1880);
        ack();

        // RW mtvec without read: legal write-only
        issue(12'h305, 2'b01, 32'h1234_5677, 1'b0, 1'b1, 4'b0, 32'h0);
        chk("tv_mtvec", csr_mtvec, 32'h1234_5674);
        chk("tv_illegal", 32'(rsp_illegal), 32'd0);
        chk("tv_rdata", rsp_rdata, 32'h0);
        ack();

        // RW mtvec with read: illegal
        issue(12'h305, 2'b01, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'b0, 32'h0);
        chk("tvr_illegal", 32'(rsp_illegal), ILL);
        chk("tvr_mtvec", csr_mtvec, 32'h1234_5674);
        chk("tvr_rdata", rsp_rdata, 32'h0);
        ack();

        // RW mhartid: write to read-only CSR
        issue(12'hF14, 2'b01, 32'h5, 1'b1, 1'b1, 4'b0, 32'h0);
        chk("hi_illegal", 32'(rsp_illegal), ILL);
        chk("hi_rdata", rsp_rdata, 32'h0);
        chk("hi_mstatus", csr_mstatus, 32'h0000_1880);
        chk("hi_mtvec", csr_mtvec, 32'h1234_5674);
        ack();

        // Unmapped address
        issue(12'h7C0, 2'b10, 32'h0, 1'b1, 1'b0, 4'b0, 32'h0);
        chk("um_illegal", 32'(rsp_illegal), ILL);
        chk("um_rdata", rsp_rdata, 32'h0);
        ack();

        // Reserved op on mstatus
        issue(12'h300, 2'b00, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'b0, 32'h0);
        chk("op0_illegal", 32'(rsp_illegal), ILL);
        chk("op0_rdata", rsp_rdata, 32'h0);
        chk("op0_mstatus", csr_mstatus, 32'h0000_1880);
        ack();

        // Internal write to mhartid, then read it back
        @(negedge clk);
        int_we    = 4'b1000;
        int_wdata = 32'h0000_0007;
        @(negedge clk);
        int_we    = 4'b0;
        int_wdata = 32'h0;
        issue(12'hF14, 2'b10, 32'h0, 1'b1, 1'b0, 4'b0, 32'h0);
        chk("hid_rdata", rsp_rdata, 32'h0000_0007);
        chk("hid_illegal", 32'(rsp_illegal), 32'd0);
        ack();

        // Internal write to ustatus during EXEC; read returns old value
        issue(12'h000, 2'b10, 32'h0, 1'b1, 1'b0, 4'b0001, 32'h55);
        chk("us_rdata_old", rsp_rdata, 32'h0);
        issue_us_again: begin
            ack();
            issue(12'h000, 2'b11, 32'h0, 1'b1, 1'b0, 4'b0, 32'h0);
            chk("us_rdata_new", rsp_rdata, 32'h0000_0055);
            ack();
        end

        // int_we and instruction write collide on mstatus
        issue(12'h300, 2'b01, 32'h0, 1'b1, 1'b0, 4'b0010, 32'hA5A5_A5A5);
        chk("col_mstatus", csr_mstatus, 32'hA5A5_A5A5);
        chk("col_rdata", rsp_rdata, 32'h0000_1880);

        // Hold response for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rdata", rsp_rdata, 32'h0000_1880);
            chk("hold_illegal", 32'(rsp_illegal), 32'd0);
        end

        // Reset while in RESP
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(rsp_valid), 32'd0);
        chk("ar_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ar_ready", 32'(req_ready), 32'd1);
        chk("ar_mstatus", csr_mstatus, 32'h0000_1880);
        chk("ar_mtvec", csr_mtvec, 32'h8000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
